// File: rtl/scc_pkg.sv
// Shared definitions for the SCC sequencer, decoder and bench.
package scc_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4,
    ST_HALT    = 3'd5,
    ST_FAULT   = 3'd6
  } state_t;

endpackage

// File: rtl/scc_mem_timer.sv
// Wait counter shared by the instruction and data memory handshakes.
// Counts cycles a request has been up without ack; flags expiry on the
// TIMEOUT-th waiting cycle unless ack arrives in that same cycle.
module scc_mem_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic ack,
  output logic expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_reg;

  // Counter is zero whenever no request waits, so every new request starts from zero.
  always_ff @(posedge clk) begin
    if (reset || !active || ack) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + CW'(1);
    end
  end

  // Ack in the final cycle wins over the timeout.
  assign expired = active && !ack && (count_reg == LAST);

endmodule

// File: rtl/scc_sequencer.sv
// Multicycle control sequencer: fetch, decode, execute, memory, writeback.
// Owns PC, retired count, halt and memory-timeout fault.
module scc_sequencer
  import scc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 16
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instruction,
  input  logic            dec_mem,
  input  logic            dec_wr_rf,
  input  logic            dec_branch,
  input  logic [XLEN-1:0] branch_target,
  input  logic            dec_halt,
  output logic            alu_en,
  output logic            dmem_req,
  input  logic            dmem_ack,
  output logic            rf_we,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] retired,
  output logic            halted,
  output logic            fault
);

  state_t          state_reg, state_next;
  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] ir_reg;
  logic [XLEN-1:0] retired_reg;
  logic            br_taken_reg;
  logic [XLEN-1:0] br_target_reg;

  logic imem_req_raw, dmem_req_raw, alu_en_raw, rf_we_raw;
  logic wait_active, wait_ack, timed_out;

  // Only one request can be up at a time, so a single timer serves both ports.
  assign wait_active = imem_req | dmem_req;
  assign wait_ack    = (imem_req & imem_ack) | (dmem_req & dmem_ack);

  scc_mem_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .active  (wait_active),
    .ack     (wait_ack),
    .expired (timed_out)
  );

  // Next-state and strobe decode; acks are honoured only while their request is up.
  always_comb begin
    state_next   = state_reg;
    imem_req_raw = 1'b0;
    dmem_req_raw = 1'b0;
    alu_en_raw   = 1'b0;
    rf_we_raw    = 1'b0;
    case (state_reg)
      ST_FETCH: begin
        imem_req_raw = 1'b1;
        if (imem_ack)       state_next = ST_DECODE;
        else if (timed_out) state_next = ST_FAULT;
      end
      ST_DECODE:  state_next = ST_EXECUTE;
      ST_EXECUTE: begin
        alu_en_raw = 1'b1;
        if (dec_halt)     state_next = ST_HALT;
        else if (dec_mem) state_next = ST_MEM;
        else              state_next = ST_WB;
      end
      ST_MEM: begin
        dmem_req_raw = 1'b1;
        if (dmem_ack)       state_next = ST_WB;
        else if (timed_out) state_next = ST_FAULT;
      end
      ST_WB: begin
        rf_we_raw  = dec_wr_rf;
        state_next = ST_FETCH;
      end
      ST_HALT:  state_next = ST_HALT;
      ST_FAULT: state_next = ST_FAULT;
      default:  state_next = ST_FAULT;
    endcase
  end

  // Strobes read as idle while reset is held, even though the state sits in FETCH.
  assign imem_req    = imem_req_raw & ~reset;
  assign dmem_req    = dmem_req_raw & ~reset;
  assign alu_en      = alu_en_raw & ~reset;
  assign rf_we       = rf_we_raw & ~reset;
  assign halted      = (state_reg == ST_HALT) & ~reset;
  assign fault       = (state_reg == ST_FAULT) & ~reset;
  assign imem_addr   = pc_reg;
  assign pc          = pc_reg;
  assign instruction = ir_reg;
  assign retired     = retired_reg;

  // Architectural registers: state, PC, IR, retired count and captured branch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_FETCH;
      pc_reg        <= RESET_PC;
      ir_reg        <= '0;
      retired_reg   <= '0;
      br_taken_reg  <= 1'b0;
      br_target_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_FETCH && imem_ack) begin
        ir_reg <= imem_rdata;
      end
      if (state_reg == ST_EXECUTE) begin
        br_taken_reg  <= dec_branch;
        br_target_reg <= branch_target;
        // A halt retires here because it never reaches writeback.
        if (dec_halt) retired_reg <= retired_reg + XLEN'(1);
      end
      if (state_reg == ST_WB) begin
        pc_reg      <= br_taken_reg ? br_target_reg : pc_reg + PC_STEP;
        retired_reg <= retired_reg + XLEN'(1);
      end
    end
  end

endmodule

// File: doc/scc_sequencer.md
# scc_sequencer

Multicycle control sequencer for the SCC datapath. It fetches each 32-bit instruction from instruction memory over a req/ack handshake and presents it to the decoder and datapath on `instruction`. It then steps the datapath through decode, execute, optional data-memory access and writeback. It owns the program counter, the retired-instruction count, the halt state and the memory-timeout fault.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `TIMEOUT`, 16, max cycles a memory request may wait for ack before a fault; must be ≥ 2

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `imem_req`  out  1  instruction fetch request
- `imem_addr`  out  32  fetch address, equals `pc`
- `imem_ack`  in  1  fetch data valid on `imem_rdata`
- `imem_rdata`  in  32  fetched instruction word
- `instruction`  out  32  latched instruction register (IR) to decoder/datapath
- `dec_mem`  in  1  decoder: instruction accesses data memory
- `dec_wr_rf`  in  1  decoder: instruction writes register file
- `dec_branch`  in  1  execute: branch taken
- `branch_target`  in  32  execute: branch destination
- `dec_halt`  in  1  decoder: halt instruction
- `alu_en`  out  1  datapath execute strobe
- `dmem_req`  out  1  data memory request
- `dmem_ack`  in  1  data memory done
- `rf_we`  out  1  register-file write enable
- `pc`  out  32  program counter
- `retired`  out  32  retired-instruction count
- `halted`  out  1  sequencer stopped by halt instruction
- `fault`  out  1  sequencer stopped by memory timeout

## Operation
- **States:** FETCH, DECODE, EXECUTE, MEM, WB, HALT, FAULT.
- **FETCH:**
  - `imem_req`=1 with `imem_addr`=`pc`.
  - On `imem_ack`: IR←`imem_rdata`, go to DECODE.
- **DECODE:** one cycle; decoder inputs are valid from the IR. Go to EXECUTE.
- **EXECUTE:** `alu_en`=1 for exactly one cycle. Next state:
  - `dec_halt` → HALT (has priority over the other two)
  - `dec_mem` → MEM
  - otherwise → WB
- **MEM:** `dmem_req`=1 until `dmem_ack`, then go to WB.
- **WB:**
  - `rf_we`=`dec_wr_rf` for one cycle.
  - `pc`←`branch_target` if `dec_branch` was captured in EXECUTE, else `pc`+4. Wraps modulo 2^32.
  - `retired` increments, wrapping at 2^32.
  - Go to FETCH.
- **HALT:**
  - `halted`=1; no requests issued; `pc` holds the halt instruction's address.
  - `retired` counts the halt instruction (incremented on the EXECUTE→HALT transition).
  - Exit only via `reset`.
- **Timeout and FAULT:**
  - A wait counter clears on entry to FETCH/MEM and increments each cycle without ack.
  - When the counter reaches `TIMEOUT` with no ack: go to FAULT, `fault`=1, requests drop, state is sticky until `reset`.
  - Ack arriving in the same cycle the count hits `TIMEOUT` wins; no fault.
- **Handshake rules:**
  - A request, once raised, stays high with its address stable until ack.
  - An ack while the corresponding request is low is ignored.
  - `dec_branch`/`branch_target` are registered in EXECUTE, so the decoder may change them afterwards.

## Timing
- **Reset values:** state=FETCH, `pc`=`RESET_PC`, IR=0, `retired`=0, all strobes/requests=0, `halted`=`fault`=0.
- `imem_req` rises the first cycle after `reset` deasserts.
- **Reset mid-operation:** at the next edge with `reset` high, all outputs take their reset values. Outstanding requests are abandoned, and a late ack afterwards is ignored unless a new request is up.
- **CPI:**
  - Zero-wait ALU op: 4 cycles (FETCH with same-cycle ack, DECODE, EXECUTE, WB).
  - Zero-wait memory op: 5 cycles.
  - Each wait cycle adds 1.
- `instruction` updates on the edge after FETCH sees ack, and is stable through WB.
- `alu_en`, `rf_we`: single-cycle pulses, never asserted simultaneously.
- `imem_req` and `dmem_req` are mutually exclusive.

## Structure
- **`scc_pkg`:** state enum (3-bit encoding), `XLEN`=32, `PC_STEP`=4 constant. The package is shared with the decoder and testbench.
- **Sub-module `scc_mem_timer`:** wait counter plus timeout compare. Instantiated once and reused for both memory interfaces.
- FSM next-state logic is combinational; registers are in a single clocked process.

## Test plan
- **ALU stream:** reset, immediate acks, three ALU ops → `pc` 0→4→8→12, `retired`=3 after 12 cycles, `rf_we` pulses at cycles 4, 8, 12.
- **Memory op:** `dec_mem`=1, `dmem_ack` after 3 wait cycles → instruction completes in 8 cycles, `dmem_req` high for 4 cycles.
- **Branch:** `dec_branch`=1, `branch_target`=32'h40 → next `imem_addr`=32'h40. Also with `pc`=32'hFFFF_FFFC and no branch → next `pc`=0.
- **Halt:** `dec_halt` with `dec_mem`=1 → HALT, `halted`=1, no further `imem_req`, `retired` incremented once.
- **Timeout:** `TIMEOUT`=16, withhold `imem_ack` → `fault`=1 on cycle 16. A second run with ack on cycle 16 → no fault.
- **Reset mid-MEM:** assert `reset` while `dmem_req`=1 → next cycle all outputs at reset values. A late `dmem_ack` has no effect.
